// File: rtl/div16_seq_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg : shared types and defaults for the div16_seq restoring divider
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = 5;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/div16_seq_if.sv
// ----------------------------------------------------------------------------
// div16_seq_if : start/busy/done request bus between sequencer and divider
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface div16_seq_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, quot, rem, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quot, rem, div_by_zero
  );

endinterface

`default_nettype wire

// File: rtl/div16_seq_sub17.sv
// ----------------------------------------------------------------------------
// sub17 : combinational W-bit subtractor with borrow out (trial subtract)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sub17 #(
  parameter int W = div_pkg::DIV_WIDTH + 1
) (
  input  wire logic [W-1:0] a,
  input  wire logic [W-1:0] b,
  output logic      [W-1:0] diff,
  output logic              borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

`default_nettype wire

// File: rtl/div16_seq.sv
// ----------------------------------------------------------------------------
// div16_seq : multi-cycle restoring divider, one trial subtract per clock.
// Optional macro DIV16_SIGNED_EN adds two's-complement operands (SIGN state).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div16_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input wire logic   clk,
  input wire logic   rst_n,
  div16_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   prem_sh;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH:0]   prem_next_full;
  logic [WIDTH-1:0] prem_next;
  logic [WIDTH-1:0] dvd_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             accept;
  logic             unused_prem_top;

  assign prem_sh = {prem_q, dvd_q[WIDTH-1]};

  sub17 #(.W(WIDTH + 1)) u_sub17 (
    .a      (prem_sh),
    .b      ({1'b0, div_q}),
    .diff   (trial),
    .borrow (borrow)
  );

  // A borrow means the trial went negative: restore the shifted remainder.
  assign prem_next_full  = borrow ? prem_sh : trial;
  assign prem_next       = prem_next_full[WIDTH-1:0];
  assign unused_prem_top = prem_next_full[WIDTH];
  assign dvd_next        = {dvd_q[WIDTH-2:0], ~borrow};

  assign accept = bus.start && ((state_q == IDLE) || (state_q == FIN));

`ifdef DIV16_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  assign a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;
`else
  assign a_mag = bus.a;
  assign b_mag = bus.b;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
`ifdef DIV16_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    case (state_q)
      RUN: begin
        cnt_d  = cnt_q + CNT_W'(1);
        prem_d = prem_next;
        dvd_d  = dvd_next;
        if (cnt_q == LAST_ITER) begin
`ifdef DIV16_SIGNED_EN
          state_d = SIGN;
`else
          state_d = FIN;
          busy_d  = 1'b0;
          quot_d  = dvd_next;
          rem_d   = prem_next;
`endif
        end
      end
`ifdef DIV16_SIGNED_EN
      SIGN: begin
        state_d = FIN;
        busy_d  = 1'b0;
        quot_d  = qneg_q ? -dvd_q : dvd_q;
        rem_d   = rneg_q ? -prem_q : prem_q;
      end
`endif
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A start taken in FIN still lets the finishing result raise done.
    if (accept) begin
      cnt_d  = '0;
      prem_d = '0;
      dvd_d  = a_mag;
      div_d  = b_mag;
`ifdef DIV16_SIGNED_EN
      qneg_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      rneg_d = bus.a[WIDTH-1];
`endif
      if (bus.b == '0) begin
        state_d = FIN;
        busy_d  = 1'b0;
        quot_d  = WIDTH'(DIV_ZERO_QUOT);
        rem_d   = bus.a;
        dbz_d   = 1'b1;
      end else begin
        state_d = RUN;
        busy_d  = 1'b1;
        dbz_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef DIV16_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
`ifdef DIV16_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

`default_nettype wire
